// File: rtl/video_timing_detector.sv
// video_timing_detector
//   Sink-side geometry analyser for a parallel RGB video stream. Measures
//   total/active pixels per line and total/active lines per frame. Reports
//   lock once LOCK_FRAMES consecutive frames measure identically, and flags
//   counter saturation (missing hs, runaway frames).
//
//   Optional feature: define FRAME_CRC_EN to add O_frame_crc, a per-frame
//   CRC-16-CCITT over the active pixels ({r,g,b}, MSB first). A CRC change
//   then also breaks lock.
//
// Ports
//   I_rgb_clk       pixel clock (only clock)
//   I_rst           synchronous reset, active high
//   I_rgb_vs/hs/de  syncs and data enable (sync polarity set by VS_POL/HS_POL)
//   I_rgb_r/g/b     pixel data (only consumed by the CRC option)
//   O_h_total       pixel clocks between hs leading edges
//   O_h_active      DE-high clocks in the last active line
//   O_v_total       hs leading edges per frame
//   O_v_active      lines with at least one DE-high clock
//   O_meas_valid    one-cycle pulse when the measurement outputs update
//   O_locked        geometry stable for LOCK_FRAMES frames
//   O_overflow      a counter saturated during the last frame
//   O_frame_crc     (FRAME_CRC_EN only) CRC of the last frame's active pixels
module video_timing_detector #(
  parameter int   CNT_W       = 12,
  parameter int   LOCK_FRAMES = 3,
  parameter logic VS_POL      = 1'b1,
  parameter logic HS_POL      = 1'b1
) (
  input  logic             I_rgb_clk,
  input  logic             I_rst,
  input  logic             I_rgb_vs,
  input  logic             I_rgb_hs,
  input  logic             I_rgb_de,
  input  logic [7:0]       I_rgb_r,
  input  logic [7:0]       I_rgb_g,
  input  logic [7:0]       I_rgb_b,
  output logic [CNT_W-1:0] O_h_total,
  output logic [CNT_W-1:0] O_h_active,
  output logic [CNT_W-1:0] O_v_total,
  output logic [CNT_W-1:0] O_v_active,
  output logic             O_meas_valid,
  output logic             O_locked,
`ifdef FRAME_CRC_EN
  output logic             O_overflow,
  output logic [15:0]      O_frame_crc
`else
  output logic             O_overflow
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic {WAIT_VS = 1'b0, MEASURE = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t           state, state_nxt;
  logic             vs_p0, hs_p0, de_p0;
  logic             vs_p1, hs_p1;
  logic             vs_lead, hs_lead, frame_end;
  logic [CNT_W-1:0] hcnt, decnt, vcnt, vact;
  logic [CNT_W-1:0] h_total_cur, h_active_cur;
  logic [CNT_W-1:0] v_active_new;
  logic             ovf_flag, ovf_now, ovf_frame;
  logic             match;
  logic [3:0]       stable_cnt, stable_nxt;

`ifdef FRAME_CRC_EN
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                           input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
    return c;
  endfunction

  logic [23:0] rgb_p0;
  logic [15:0] crc_run;
`else
  logic unused_rgb;
  assign unused_rgb = ^{I_rgb_r, I_rgb_g, I_rgb_b};
`endif

  // ---- stage p0: register pins, syncs normalised to 1 = active ----
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      vs_p0 <= 1'b0;
      hs_p0 <= 1'b0;
      de_p0 <= 1'b0;
      vs_p1 <= 1'b0;
      hs_p1 <= 1'b0;
    end else begin
      vs_p0 <= (I_rgb_vs == VS_POL);
      hs_p0 <= (I_rgb_hs == HS_POL);
      de_p0 <= I_rgb_de;
      vs_p1 <= vs_p0;
      hs_p1 <= hs_p0;
    end
  end

`ifdef FRAME_CRC_EN
  always_ff @(posedge I_rgb_clk) rgb_p0 <= {I_rgb_r, I_rgb_g, I_rgb_b};
`endif

  assign vs_lead = vs_p0 & ~vs_p1;
  assign hs_lead = hs_p0 & ~hs_p1;

  // ---- stage p1: FSM, counters, frame-end evaluation ----
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) state <= WAIT_VS;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      WAIT_VS: if (vs_lead) state_nxt = MEASURE;
      MEASURE: frame_end = vs_lead;
      default: state_nxt = WAIT_VS;
    endcase
  end

  always_comb begin
    ovf_now   = (hcnt == CNT_MAX) || (decnt == CNT_MAX) ||
                (vcnt == CNT_MAX) || (vact == CNT_MAX);
    ovf_frame = ovf_flag || ovf_now;
    // A line still open at the vs edge that carried DE belongs to the
    // frame that is ending.
    v_active_new = (decnt != '0) ? sat_inc(vact) : vact;
    match = (h_total_cur  == O_h_total)  && (h_active_cur == O_h_active) &&
            (vcnt         == O_v_total)  && (v_active_new == O_v_active) &&
            !ovf_frame;
`ifdef FRAME_CRC_EN
    match = match && (crc_run == O_frame_crc);
`endif
    if (match)          stable_nxt = (stable_cnt >= LOCK_N) ? LOCK_N : stable_cnt + 4'd1;
    else if (ovf_frame) stable_nxt = 4'd0;
    else                stable_nxt = 4'd1;
  end

  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      hcnt         <= '0;
      decnt        <= '0;
      vcnt         <= '0;
      vact         <= '0;
      h_total_cur  <= '0;
      h_active_cur <= '0;
      ovf_flag     <= 1'b0;
      stable_cnt   <= '0;
      O_h_total    <= '0;
      O_h_active   <= '0;
      O_v_total    <= '0;
      O_v_active   <= '0;
      O_meas_valid <= 1'b0;
      O_locked     <= 1'b0;
      O_overflow   <= 1'b0;
    end else begin
      if (hs_lead) begin
        h_total_cur <= sat_inc(hcnt);
        hcnt        <= '0;
        if (decnt != '0) h_active_cur <= decnt;
      end else begin
        hcnt <= sat_inc(hcnt);
      end

      // The DE count restarts at a vs edge too, so a line spanning the vs
      // edge is not counted active in both frames. The current clock's DE
      // belongs to the new line/frame.
      if (hs_lead || vs_lead) decnt <= de_p0 ? CNT_ONE : '0;
      else if (de_p0)         decnt <= sat_inc(decnt);

      if (vs_lead) begin
        // An hs edge coinciding with the vs edge opens line 1 of the new frame.
        vcnt     <= hs_lead ? CNT_ONE : '0;
        vact     <= '0;
        ovf_flag <= 1'b0;
      end else begin
        if (hs_lead) begin
          vcnt <= sat_inc(vcnt);
          if (decnt != '0) vact <= sat_inc(vact);
        end
        if (ovf_now) ovf_flag <= 1'b1;
      end

      O_meas_valid <= frame_end;
      if (frame_end) begin
        O_h_total  <= h_total_cur;
        O_h_active <= h_active_cur;
        O_v_total  <= vcnt;
        O_v_active <= v_active_new;
        O_overflow <= ovf_frame;
        stable_cnt <= stable_nxt;
        O_locked   <= (stable_nxt >= LOCK_N);
      end
    end
  end

`ifdef FRAME_CRC_EN
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      crc_run     <= CRC_INIT;
      O_frame_crc <= '0;
    end else begin
      if (vs_lead)     crc_run <= de_p0 ? crc_step(CRC_INIT, rgb_p0) : CRC_INIT;
      else if (de_p0)  crc_run <= crc_step(crc_run, rgb_p0);
      if (frame_end) O_frame_crc <= crc_run;
    end
  end
`endif

endmodule
